// File: rtl/bank_map_pkg.sv
// bank_map_pkg
//   Shared types and the (row, col) -> (bank, entry) mapping used by the
//   banked scatter scheduler.
//   - BANK_W / RW     : bank-index and row-index widths for the default tile
//   - state_t         : scheduler FSM states
//   - bank_loc_t      : mapped location (bank, entry), kept 32 bits wide so
//                       callers with any geometry can take the low bits
//   - map_rc()        : skewed, bitwidth-packed bank/entry mapping
package bank_map_pkg;

  localparam int BANK_COUNT_DEF = 32;
  localparam int TILE_SIZE_DEF  = 256;
  localparam int BANK_W         = $clog2(BANK_COUNT_DEF);
  localparam int RW             = $clog2(TILE_SIZE_DEF);

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  typedef struct packed {
    logic [31:0] bank;
    logic [31:0] entry;
  } bank_loc_t;

  // Rows are packed (1<<bw) per entry. The row-group index ru rotates the
  // bank by ru*skew, and the sub-row rs spreads packed rows across evenly
  // spaced banks. All arithmetic is 32 bits wide, so nothing is truncated
  // before the final modulo.
  function automatic bank_loc_t map_rc(input logic [31:0] row,
                                       input logic [31:0] col,
                                       input logic [31:0] bw,
                                       input logic [31:0] bank_count,
                                       input logic [31:0] skew);
    logic [31:0] ru;
    logic [31:0] rs;
    logic [31:0] shift;
    logic [31:0] rs_off;
    bank_loc_t   loc;
    ru        = row >> bw;
    rs        = row & ((32'd1 << bw) - 32'd1);
    shift     = (ru * skew) % bank_count;
    rs_off    = rs * (bank_count >> bw);
    loc.bank  = (col + shift + rs_off) % bank_count;
    loc.entry = ru;
    return loc;
  endfunction

endpackage

// File: rtl/bank_lane_arbiter.sv
// bank_lane_arbiter
//   Combinational fixed-priority arbitration of pending lanes onto banks.
//   For every bank, the lowest-index pending lane targeting it wins.
//   pending_i   : lanes still waiting to write
//   lane_bank_i : target bank of each lane, lane l at [l*BANK_W +: BANK_W]
//   grant_o     : lanes that win their bank this cycle
//   bank_sel_o  : winning lane index per bank, bank b at [b*LANE_W +: LANE_W]
//   bank_hit_o  : bank has a winner this cycle
module bank_lane_arbiter #(
  parameter int BANK_COUNT = 32,
  parameter int PORT_COUNT = 4,
  parameter int BANK_W     = 5,
  parameter int LANE_W     = 2
) (
  input  logic [PORT_COUNT-1:0]        pending_i,
  input  logic [PORT_COUNT*BANK_W-1:0] lane_bank_i,
  output logic [PORT_COUNT-1:0]        grant_o,
  output logic [BANK_COUNT*LANE_W-1:0] bank_sel_o,
  output logic [BANK_COUNT-1:0]        bank_hit_o
);

  // A lane is granted unless a lower-index pending lane shares its bank.
  always_comb begin
    grant_o = '0;
    for (int l = 0; l < PORT_COUNT; l++) begin
      grant_o[l] = pending_i[l];
      for (int m = 0; m < l; m++) begin
        if (pending_i[m] &&
            lane_bank_i[m*BANK_W +: BANK_W] == lane_bank_i[l*BANK_W +: BANK_W]) begin
          grant_o[l] = 1'b0;
        end
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < BANK_COUNT; gi++) begin : g_bank
      logic [LANE_W-1:0] sel;
      logic              hit;
      // Scan from the top so the lowest matching lane is the last to land.
      always_comb begin
        sel = '0;
        hit = 1'b0;
        for (int l = PORT_COUNT - 1; l >= 0; l--) begin
          if (pending_i[l] && lane_bank_i[l*BANK_W +: BANK_W] == BANK_W'(gi)) begin
            sel = LANE_W'(l);
            hit = 1'b1;
          end
        end
      end
      assign bank_sel_o[gi*LANE_W +: LANE_W] = sel;
      assign bank_hit_o[gi]                  = hit;
    end
  endgenerate

endmodule

// File: rtl/banked_scatter_scheduler.sv
// banked_scatter_scheduler
//   Accepts a batch of up to PORT_COUNT (row, col, data) writes, maps each
//   to a skewed (bank, entry) slot, and issues them to the per-bank write
//   ports. Lanes that collide on a bank are serialised in lane order.
//   clk, reset              : clock, asynchronous active-high reset
//   in_valid / in_ready     : batch handshake (ready only while idle)
//   in_lane_valid           : per-lane enable
//   in_row/in_col/in_data   : lane payloads, lane i at [i*W +: W]
//   in_bitwidth             : row-packing mode, sampled at acceptance
//   bank_wr_en/entry/data   : per-bank write port, zero when not enabled
//   busy                    : a batch is being issued
//   clear_stats             : synchronous clear of conflict_cycles
//   conflict_cycles         : saturating count of extra issue cycles
module banked_scatter_scheduler
  import bank_map_pkg::*;
#(
  parameter int BANK_COUNT = 32,
  parameter int TILE_SIZE  = 256,
  parameter int PORT_COUNT = 4,
  parameter int DATA_W     = 16,
  parameter int SKEW       = 3,
  parameter int STAT_W     = 32,
  localparam int BNK_W     = $clog2(BANK_COUNT),
  localparam int ROW_W     = $clog2(TILE_SIZE),
  localparam int LANE_W    = (PORT_COUNT > 1) ? $clog2(PORT_COUNT) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [PORT_COUNT-1:0]        in_lane_valid,
  input  logic [PORT_COUNT*ROW_W-1:0]  in_row,
  input  logic [PORT_COUNT*ROW_W-1:0]  in_col,
  input  logic [PORT_COUNT*DATA_W-1:0] in_data,
  input  logic [1:0]                   in_bitwidth,
  output logic [BANK_COUNT-1:0]        bank_wr_en,
  output logic [BANK_COUNT*ROW_W-1:0]  bank_wr_entry,
  output logic [BANK_COUNT*DATA_W-1:0] bank_wr_data,
  output logic                         busy,
  input  logic                         clear_stats,
  output logic [STAT_W-1:0]            conflict_cycles
);

  state_t                      state_q, state_d;
  logic [PORT_COUNT-1:0]       pending_q, pending_d;
  logic                        first_q, first_d;
  logic [STAT_W-1:0]           conflict_q, conflict_d;
  logic [PORT_COUNT*BNK_W-1:0] lane_bank_q, lane_bank_d;
  logic [ROW_W-1:0]            lane_entry_q [PORT_COUNT];
  logic [ROW_W-1:0]            lane_entry_d [PORT_COUNT];
  logic [DATA_W-1:0]           lane_data_q  [PORT_COUNT];
  logic [DATA_W-1:0]           lane_data_d  [PORT_COUNT];

  logic [PORT_COUNT*BNK_W-1:0] map_bank;
  logic [ROW_W-1:0]            map_entry [PORT_COUNT];
  logic [31:0]                 bw_eff;
  logic [PORT_COUNT-1:0]       grant;
  logic [BANK_COUNT*LANE_W-1:0] bank_sel;
  logic [BANK_COUNT-1:0]       bank_hit;

  // Packing more rows than banks is meaningless; fall back to full packing.
  assign bw_eff = (32'(in_bitwidth) > 32'(BNK_W)) ? 32'(BNK_W) : 32'(in_bitwidth);

  assert property (@(posedge clk) disable iff (reset)
                   (in_valid && in_ready) |-> (32'(in_bitwidth) <= 32'(BNK_W)));

  genvar gi;
  generate
    for (gi = 0; gi < PORT_COUNT; gi++) begin : g_map
      bank_loc_t loc;
      logic      lane_unused;
      assign loc = map_rc(32'(in_row[gi*ROW_W +: ROW_W]), 32'(in_col[gi*ROW_W +: ROW_W]),
                          bw_eff, 32'(BANK_COUNT), 32'(SKEW));
      assign map_bank[gi*BNK_W +: BNK_W] = loc.bank[BNK_W-1:0];
      assign map_entry[gi]               = loc.entry[ROW_W-1:0];
      // Upper bits are zero by construction (modulo / row range).
      assign lane_unused = ^{loc.bank[31:BNK_W], loc.entry[31:ROW_W]};
    end
  endgenerate

  bank_lane_arbiter #(
    .BANK_COUNT (BANK_COUNT),
    .PORT_COUNT (PORT_COUNT),
    .BANK_W     (BNK_W),
    .LANE_W     (LANE_W)
  ) u_arbiter (
    .pending_i   (pending_q),
    .lane_bank_i (lane_bank_q),
    .grant_o     (grant),
    .bank_sel_o  (bank_sel),
    .bank_hit_o  (bank_hit)
  );

  // Write ports are decoded purely from registered lane state.
  generate
    for (gi = 0; gi < BANK_COUNT; gi++) begin : g_port
      logic [LANE_W-1:0] sel;
      assign sel                                = bank_sel[gi*LANE_W +: LANE_W];
      assign bank_wr_en[gi]                     = bank_hit[gi];
      assign bank_wr_entry[gi*ROW_W +: ROW_W]   = bank_hit[gi] ? lane_entry_q[sel] : '0;
      assign bank_wr_data[gi*DATA_W +: DATA_W]  = bank_hit[gi] ? lane_data_q[sel]  : '0;
    end
  endgenerate

  assign conflict_cycles = conflict_q;

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    first_d      = first_q;
    conflict_d   = conflict_q;
    lane_bank_d  = lane_bank_q;
    lane_entry_d = lane_entry_q;
    lane_data_d  = lane_data_q;
    in_ready     = 1'b0;
    busy         = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        // An empty batch is consumed by the handshake but issues nothing.
        if (in_valid && (in_lane_valid != '0)) begin
          state_d     = ISSUE;
          pending_d   = in_lane_valid;
          first_d     = 1'b1;
          lane_bank_d = map_bank;
          for (int l = 0; l < PORT_COUNT; l++) begin
            lane_entry_d[l] = map_entry[l];
            lane_data_d[l]  = in_data[l*DATA_W +: DATA_W];
          end
        end
      end
      ISSUE: begin
        busy      = 1'b1;
        first_d   = 1'b0;
        pending_d = pending_q & ~grant;
        if (!first_q && (conflict_q != '1)) begin
          conflict_d = conflict_q + 1'b1;
        end
        if ((pending_q & ~grant) == '0) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (clear_stats) begin
      conflict_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      first_q     <= 1'b0;
      conflict_q  <= '0;
      lane_bank_q <= '0;
      for (int l = 0; l < PORT_COUNT; l++) begin
        lane_entry_q[l] <= '0;
        lane_data_q[l]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      first_q     <= first_d;
      conflict_q  <= conflict_d;
      lane_bank_q <= lane_bank_d;
      for (int l = 0; l < PORT_COUNT; l++) begin
        lane_entry_q[l] <= lane_entry_d[l];
        lane_data_q[l]  <= lane_data_d[l];
      end
    end
  end

endmodule

// File: tb/tb_banked_scatter_scheduler.sv
// Directed testbench for banked_scatter_scheduler (default geometry:
// 32 banks, 256-row tile, 4 lanes, 16-bit data, skew 3).
module tb_banked_scatter_scheduler;

  localparam int BC = 32;
  localparam int RB = 8;
  localparam int PC = 4;
  localparam int DW = 16;
  localparam int SW = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [PC-1:0]    in_lane_valid;
  logic [PC*RB-1:0] in_row;
  logic [PC*RB-1:0] in_col;
  logic [PC*DW-1:0] in_data;
  logic [1:0]       in_bitwidth;
  logic [BC-1:0]    bank_wr_en;
  logic [BC*RB-1:0] bank_wr_entry;
  logic [BC*DW-1:0] bank_wr_data;
  logic             busy;
  logic             clear_stats;
  logic [SW-1:0]    conflict_cycles;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  banked_scatter_scheduler dut (
    .clk             (clk),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_lane_valid   (in_lane_valid),
    .in_row          (in_row),
    .in_col          (in_col),
    .in_data         (in_data),
    .in_bitwidth     (in_bitwidth),
    .bank_wr_en      (bank_wr_en),
    .bank_wr_entry   (bank_wr_entry),
    .bank_wr_data    (bank_wr_data),
    .busy            (busy),
    .clear_stats     (clear_stats),
    .conflict_cycles (conflict_cycles)
  );

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // Stimulus helpers (no checking inside).
  task automatic set_lane(input int i, input int row, input int col, input logic [15:0] d);
    in_row[i*RB +: RB]  = row[7:0];
    in_col[i*RB +: RB]  = col[7:0];
    in_data[i*DW +: DW] = d;
  endtask

  // Called at a negedge while idle; returns at the negedge of issue cycle 1.
  task automatic launch(input logic [3:0] lv, input logic [1:0] bw);
    in_lane_valid = lv;
    in_bitwidth   = bw;
    in_valid      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid      = 1'b0;
    in_lane_valid = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_lane_valid = '0; in_row = '0; in_col = '0;
    in_data = '0; in_bitwidth = '0; clear_stats = 1'b0;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (bank_wr_en !== 32'h0) begin errors++; $display("FAIL reset_en got %h want 0", bank_wr_en); end
    checks++; if (conflict_cycles !== 32'd0) begin errors++; $display("FAIL reset_conflict got %0d want 0", conflict_cycles); end
    $display("txn reset: ready=%b busy=%b en=%h", in_ready, busy, bank_wr_en);
  endtask

  // bw=0, banks 0,3,3,8 -> two issue cycles.
  task automatic test_basic();
    set_lane(0, 0, 0, 16'hA000); set_lane(1, 1, 0, 16'hA001);
    set_lane(2, 0, 3, 16'hA002); set_lane(3, 2, 2, 16'hA003);
    launch(4'b1111, 2'd0);
    checks++; if (bank_wr_en !== 32'h0000_0109) begin errors++; $display("FAIL basic_c1_en got %h want 00000109", bank_wr_en); end
    checks++; if (bank_wr_entry[3*RB +: RB] !== 8'd1 || bank_wr_data[3*DW +: DW] !== 16'hA001) begin
      errors++; $display("FAIL basic_c1_bank3 got e%0d d%h want e1 dA001", bank_wr_entry[3*RB +: RB], bank_wr_data[3*DW +: DW]); end
    checks++; if (bank_wr_entry[8*RB +: RB] !== 8'd2 || bank_wr_data[8*DW +: DW] !== 16'hA003) begin
      errors++; $display("FAIL basic_c1_bank8 got e%0d d%h want e2 dA003", bank_wr_entry[8*RB +: RB], bank_wr_data[8*DW +: DW]); end
    checks++; if (bank_wr_data[0 +: DW] !== 16'hA000 || in_ready !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL basic_c1_misc got d0=%h ready=%b busy=%b want A000 0 1", bank_wr_data[0 +: DW], in_ready, busy); end
    @(negedge clk);
    checks++; if (bank_wr_en !== 32'h0000_0008) begin errors++; $display("FAIL basic_c2_en got %h want 00000008", bank_wr_en); end
    checks++; if (bank_wr_entry[3*RB +: RB] !== 8'd0 || bank_wr_data[3*DW +: DW] !== 16'hA002) begin
      errors++; $display("FAIL basic_c2_bank3 got e%0d d%h want e0 dA002", bank_wr_entry[3*RB +: RB], bank_wr_data[3*DW +: DW]); end
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0 || bank_wr_en !== 32'h0) begin
      errors++; $display("FAIL basic_c3_idle got ready=%b busy=%b en=%h want 1 0 0", in_ready, busy, bank_wr_en); end
    checks++; if (conflict_cycles !== 32'd1) begin errors++; $display("FAIL basic_conflict got %0d want 1", conflict_cycles); end
    $display("txn basic bw0: conflict=%0d", conflict_cycles);
  endtask

  // bw=1, row5 col1 -> bank 23 entry 2.
  task automatic test_single();
    set_lane(0, 5, 1, 16'hBEEF);
    launch(4'b0001, 2'd1);
    checks++; if (bank_wr_en !== 32'h0080_0000) begin errors++; $display("FAIL single_en got %h want 00800000", bank_wr_en); end
    checks++; if (bank_wr_entry[23*RB +: RB] !== 8'd2 || bank_wr_data[23*DW +: DW] !== 16'hBEEF) begin
      errors++; $display("FAIL single_bank23 got e%0d d%h want e2 dBEEF", bank_wr_entry[23*RB +: RB], bank_wr_data[23*DW +: DW]); end
    checks++; if (bank_wr_entry !== {8'd0, 8'd2, {23{8'd0}}}) begin
      errors++; $display("FAIL single_entry_zero got %h", bank_wr_entry); end
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || conflict_cycles !== 32'd1) begin
      errors++; $display("FAIL single_done got ready=%b conflict=%0d want 1 1", in_ready, conflict_cycles); end
    $display("txn single bw1: bank23 written");
  endtask

  // bw=2: row7 col31 -> bank 26 e1; row255 col0 -> bank 21 e63.
  task automatic test_bw2();
    set_lane(0, 7, 31, 16'h0707); set_lane(1, 255, 0, 16'hFF00);
    launch(4'b0011, 2'd2);
    checks++; if (bank_wr_en !== 32'h0420_0000) begin errors++; $display("FAIL bw2_en got %h want 04200000", bank_wr_en); end
    checks++; if (bank_wr_entry[26*RB +: RB] !== 8'd1 || bank_wr_data[26*DW +: DW] !== 16'h0707) begin
      errors++; $display("FAIL bw2_bank26 got e%0d d%h want e1 d0707", bank_wr_entry[26*RB +: RB], bank_wr_data[26*DW +: DW]); end
    checks++; if (bank_wr_entry[21*RB +: RB] !== 8'd63 || bank_wr_data[21*DW +: DW] !== 16'hFF00) begin
      errors++; $display("FAIL bw2_bank21 got e%0d d%h want e63 dFF00", bank_wr_entry[21*RB +: RB], bank_wr_data[21*DW +: DW]); end
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || conflict_cycles !== 32'd1) begin
      errors++; $display("FAIL bw2_done got ready=%b conflict=%0d want 1 1", in_ready, conflict_cycles); end
    $display("txn bw2: banks 26,21");
  endtask

  // All lanes -> bank 5 with entries 0..3.
  task automatic setup_four_way();
    set_lane(0, 0, 5, 16'hC000); set_lane(1, 1, 2, 16'hC001);
    set_lane(2, 2, 31, 16'hC002); set_lane(3, 3, 28, 16'hC003);
  endtask

  task automatic test_four_way();
    logic [15:0] exp_d;
    setup_four_way();
    launch(4'b1111, 2'd0);
    for (int c = 0; c < 4; c++) begin
      exp_d = 16'hC000 + 16'(c);
      checks++; if (bank_wr_en !== 32'h0000_0020 || in_ready !== 1'b0) begin
        errors++; $display("FAIL four_c%0d_en got %h ready=%b want 00000020 0", c, bank_wr_en, in_ready); end
      checks++; if (bank_wr_entry[5*RB +: RB] !== 8'(c) || bank_wr_data[5*DW +: DW] !== exp_d) begin
        errors++; $display("FAIL four_c%0d_lane got e%0d d%h want e%0d d%h", c,
                           bank_wr_entry[5*RB +: RB], bank_wr_data[5*DW +: DW], c, exp_d); end
      @(negedge clk);
    end
    checks++; if (in_ready !== 1'b1 || bank_wr_en !== 32'h0) begin
      errors++; $display("FAIL four_done got ready=%b en=%h want 1 0", in_ready, bank_wr_en); end
    checks++; if (conflict_cycles !== 32'd4) begin errors++; $display("FAIL four_conflict got %0d want 4", conflict_cycles); end
    $display("txn four_way: conflict=%0d", conflict_cycles);
  endtask

  // Empty batch is consumed in IDLE; a real batch follows on the next edge.
  task automatic test_zero_lanes();
    in_valid = 1'b1; in_lane_valid = 4'b0000; in_bitwidth = 2'd0;
    @(posedge clk); @(negedge clk);
    checks++; if (busy !== 1'b0 || bank_wr_en !== 32'h0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL zero_idle got busy=%b en=%h ready=%b want 0 0 1", busy, bank_wr_en, in_ready); end
    set_lane(0, 5, 1, 16'h1234);
    in_lane_valid = 4'b0001; in_bitwidth = 2'd1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0; in_lane_valid = '0;
    checks++; if (bank_wr_en !== 32'h0080_0000 || bank_wr_data[23*DW +: DW] !== 16'h1234) begin
      errors++; $display("FAIL zero_next got en=%h d=%h want 00800000 1234", bank_wr_en, bank_wr_data[23*DW +: DW]); end
    @(negedge clk);
    $display("txn zero_lanes then single");
  endtask

  // Duplicate (row,col) in lanes 0 and 1: bank 13 entry 3, lane order.
  task automatic test_duplicate();
    set_lane(0, 3, 4, 16'hD000); set_lane(1, 3, 4, 16'hD001);
    launch(4'b0011, 2'd0);
    checks++; if (bank_wr_en !== 32'h0000_2000 || bank_wr_entry[13*RB +: RB] !== 8'd3 || bank_wr_data[13*DW +: DW] !== 16'hD000) begin
      errors++; $display("FAIL dup_c1 got en=%h e%0d d%h want 00002000 e3 dD000", bank_wr_en, bank_wr_entry[13*RB +: RB], bank_wr_data[13*DW +: DW]); end
    @(negedge clk);
    checks++; if (bank_wr_en !== 32'h0000_2000 || bank_wr_data[13*DW +: DW] !== 16'hD001) begin
      errors++; $display("FAIL dup_c2 got en=%h d%h want 00002000 dD001", bank_wr_en, bank_wr_data[13*DW +: DW]); end
    @(negedge clk);
    checks++; if (conflict_cycles !== 32'd5) begin errors++; $display("FAIL dup_conflict got %0d want 5", conflict_cycles); end
    $display("txn duplicate: conflict=%0d", conflict_cycles);
  endtask

  // Reset during issue cycle 2 of the four-way conflict.
  task automatic test_reset_mid();
    setup_four_way();
    launch(4'b1111, 2'd0);
    @(negedge clk);
    checks++; if (bank_wr_en !== 32'h0000_0020 || conflict_cycles !== 32'd5) begin
      errors++; $display("FAIL rstmid_pre got en=%h conflict=%0d want 00000020 5", bank_wr_en, conflict_cycles); end
    reset = 1'b1;
    #1;
    checks++; if (bank_wr_en !== 32'h0 || busy !== 1'b0 || conflict_cycles !== 32'd0) begin
      errors++; $display("FAIL rstmid_async got en=%h busy=%b conflict=%0d want 0 0 0", bank_wr_en, busy, conflict_cycles); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || bank_wr_en !== 32'h0 || busy !== 1'b0) begin
      errors++; $display("FAIL rstmid_after got ready=%b en=%h busy=%b want 1 0 0", in_ready, bank_wr_en, busy); end
    $display("txn reset_mid: batch dropped");
  endtask

  // clear_stats coinciding with an increment wins.
  task automatic test_clear_stats();
    set_lane(0, 0, 0, 16'hE000); set_lane(1, 1, 0, 16'hE001);
    set_lane(2, 0, 3, 16'hE002); set_lane(3, 2, 2, 16'hE003);
    launch(4'b1111, 2'd0);
    @(negedge clk); @(negedge clk);
    checks++; if (conflict_cycles !== 32'd1) begin errors++; $display("FAIL clear_pre got %0d want 1", conflict_cycles); end
    launch(4'b1111, 2'd0);
    @(negedge clk);
    clear_stats = 1'b1;
    @(negedge clk);
    clear_stats = 1'b0;
    checks++; if (conflict_cycles !== 32'd0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL clear_with_incr got conflict=%0d ready=%b want 0 1", conflict_cycles, in_ready); end
    $display("txn clear_stats: conflict=%0d", conflict_cycles);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single();
    test_bw2();
    test_four_way();
    test_zero_lanes();
    test_duplicate();
    test_reset_mid();
    test_clear_stats();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
